mips_commit_trace: RTL
======================

Name: mips_commit_trace

Overview:
Synthesizable commit-trace unit for the MIPS pipeline, and the in-hardware successor to per-cycle WB/MEM logging. It snoops register writebacks from WB and stores from MEM, then timestamps each event with a cycle counter. Events are stored in a parametrised circular buffer and read out after capture stops. Supports a trigger cycle, stop-on-full or wrap mode, collision buffering and drop accounting.

Parameters:
DATA_WIDTH, 32, data and address width; matches `DATA_WIDTH
DEPTH, 16, trace entries; power of 2, >= 2
TS_WIDTH, 16, timestamp/cycle counter width
TAG_WIDTH, 8, tag width; >= 5
WRAP, 0, 0 = stop when full; 1 = overwrite oldest

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_arm  in  1  clear the buffer and arm the trigger
i_stop  in  1  force stop
i_trig_cycle  in  TS_WIDTH  cycle value at which capture begins
i_wb_reg_write  in  1  WB register write strobe
i_wb_write_register  in  5  WB destination register
i_wb_write_data  in  DATA_WIDTH  WB write data
i_mem_write  in  1  MEM store strobe
i_mem_addr  in  DATA_WIDTH  store byte address
i_mem_write_data  in  DATA_WIDTH  store data
i_rd_en  in  1  pop the oldest entry
o_rd_valid  out  1  o_rd_entry valid
o_rd_entry  out  1+TAG_WIDTH+DATA_WIDTH+TS_WIDTH  {kind, tag, data, ts}, MSB first
o_count  out  $clog2(DEPTH)+1  entries held
o_dropped  out  16  lost events, saturating
o_state  out  2  FSM state
o_cycle  out  TS_WIDTH  cycle counter

Behaviour:
- Only one clock exists. Reset is synchronous and active-high: state IDLE; all pointers, counters and outputs are 0; the pending slot is empty.
- o_cycle increments every cycle after reset and wraps modulo 2^TS_WIDTH.
- FSM states: IDLE=0, ARMED=1, CAPTURE=2, STOPPED=3.
- IDLE --i_arm--> ARMED. STOPPED --i_arm--> ARMED. Either transition clears the pointers, o_count, o_dropped and the pending slot.
- ARMED --(o_cycle == i_trig_cycle)--> CAPTURE. Capture starts the following cycle. The compare is an equality, so it is wrap-safe.
- CAPTURE --i_stop--> STOPPED.
- CAPTURE --(WRAP=0 and o_count reaches DEPTH)--> STOPPED.
- IDLE or ARMED --i_stop--> STOPPED, with an empty buffer.
- i_arm is ignored in ARMED and CAPTURE. i_stop has priority over i_arm when both are asserted in the same cycle.
- Events are captured only in CAPTURE:
  - Register event: i_wb_reg_write && i_wb_write_register != 0. Entry kind=0, tag = zero-extended register number.
  - Memory event: i_mem_write. Entry kind=1, tag = i_mem_addr[TAG_WIDTH+1:2].
  - ts = o_cycle in the event cycle.
- At most one buffer write per cycle. Candidates are ordered pending, register, memory.
  - The first candidate is written.
  - The second candidate goes into the single pending slot, keeping its original ts.
  - Any further candidate is dropped and o_dropped increments (saturating at 0xFFFF).
- On leaving CAPTURE, an occupied pending slot is discarded and counted as dropped.
- WRAP=1 and buffer full: a write overwrites the oldest entry, the read pointer advances, and o_count stays at DEPTH. No drop is counted.
- Readout:
  - Allowed only in STOPPED.
  - i_rd_en with o_count > 0: o_rd_valid=1 the next cycle, o_rd_entry = oldest entry, o_count decrements.
  - i_rd_en with o_count == 0, or in any other state: ignored, o_rd_valid=0.
  - o_rd_entry holds its last value when o_rd_valid=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- Reset mid-capture or mid-readout returns the block to IDLE immediately and clears all contents.

Decomposition:
- Shared package (mips_pkg.vh): TRACE_IDLE/ARMED/CAPTURE/STOPPED state codes, TRACE_KIND_REG/MEM, entry field offsets.
- Sub-module trace_ram: DEPTH x ENTRY_W storage, one write port, registered read port. Provides the 1-cycle read latency.

Test Plan:
- Reset, arm with trig=5 at cycle 2; register event at cycles 3 and 8 -> only the cycle-8 event is captured; i_stop, then read gives {0, 5, data, ts=8}, o_count 1->0.
- WRAP=0, DEPTH=4; 6 register events ($1..$6, data 10..60) -> STOPPED after the 4th; reads return $1..$4; o_dropped=0.
- WRAP=1, DEPTH=4; same 6 events, then stop -> reads return $3..$6; o_count=4 before reading.
- Same cycle t: WB $7=10 plus store addr 100, data 5 -> entries $7 (ts=t), then mem tag 25 (ts=t) written at t+1. Adding a second collision at t+1 -> o_dropped=1.
- Register write to $0 during CAPTURE -> nothing captured. i_rd_en while in CAPTURE -> o_rd_valid stays 0.
- Reset asserted during CAPTURE with 3 entries -> state IDLE, o_count=0, o_cycle=0 on the next cycle.

Source files
------------

// File: rtl/mips_commit_trace_pkg.sv
// Shared definitions for the MIPS commit-trace unit.
// Holds the trace FSM state codes, the event kind encodings and a helper
// that computes the packed entry width / field offsets from the block
// parameters. Entry layout, MSB first: {kind, tag, data, ts}.
package mips_commit_trace_pkg;

  typedef enum logic [1:0] {
    TRACE_IDLE    = 2'd0,
    TRACE_ARMED   = 2'd1,
    TRACE_CAPTURE = 2'd2,
    TRACE_STOPPED = 2'd3
  } trace_state_e;

  localparam logic TRACE_KIND_REG = 1'b0;
  localparam logic TRACE_KIND_MEM = 1'b1;

  // Total entry width.
  function automatic int unsigned trace_entry_w(input int unsigned tag_w,
                                                input int unsigned data_w,
                                                input int unsigned ts_w);
    return 1 + tag_w + data_w + ts_w;
  endfunction

  // Field offsets (LSB position of each field).
  function automatic int unsigned trace_ts_lsb();
    return 0;
  endfunction

  function automatic int unsigned trace_data_lsb(input int unsigned ts_w);
    return ts_w;
  endfunction

  function automatic int unsigned trace_tag_lsb(input int unsigned data_w,
                                                input int unsigned ts_w);
    return data_w + ts_w;
  endfunction

  function automatic int unsigned trace_kind_lsb(input int unsigned tag_w,
                                                 input int unsigned data_w,
                                                 input int unsigned ts_w);
    return tag_w + data_w + ts_w;
  endfunction

endpackage

// File: rtl/mips_commit_trace_ram.sv
// Trace entry storage: DEPTH x ENTRY_W, one write port and one registered
// read port (1-cycle read latency). The read register is reset to zero and
// holds its value whenever no read is requested.
// Ports:
//   clk, reset           clock, synchronous active-high reset (read reg only)
//   we_i, waddr_i, wdata_i  write port
//   re_i, raddr_i        read request and address
//   rdata_o              registered read data
module mips_commit_trace_ram #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ENTRY_W = 57
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [ENTRY_W-1:0]       wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [ENTRY_W-1:0]       rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_commit_trace.sv
// Commit-trace unit: snoops WB register writes and MEM stores, timestamps
// them with a free-running cycle counter and stores them in a circular
// buffer that is read out once capture has stopped.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_arm, i_stop              arm (clears buffer) / force stop
//   i_trig_cycle               cycle at which ARMED moves to CAPTURE
//   i_wb_*                     WB register writeback snoop
//   i_mem_*                    MEM store snoop
//   i_rd_en                    pop oldest entry (STOPPED only)
//   o_rd_valid, o_rd_entry     read result {kind, tag, data, ts}
//   o_count, o_dropped         entries held, saturating lost-event count
//   o_state, o_cycle           FSM state, cycle counter
module mips_commit_trace
  import mips_commit_trace_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TS_WIDTH   = 16,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned WRAP       = 0
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     i_arm,
  input  logic                                     i_stop,
  input  logic [TS_WIDTH-1:0]                      i_trig_cycle,
  input  logic                                     i_wb_reg_write,
  input  logic [4:0]                               i_wb_write_register,
  input  logic [DATA_WIDTH-1:0]                    i_wb_write_data,
  input  logic                                     i_mem_write,
  input  logic [DATA_WIDTH-1:0]                    i_mem_addr,
  input  logic [DATA_WIDTH-1:0]                    i_mem_write_data,
  input  logic                                     i_rd_en,
  output logic                                     o_rd_valid,
  output logic [1+TAG_WIDTH+DATA_WIDTH+TS_WIDTH-1:0] o_rd_entry,
  output logic [$clog2(DEPTH):0]                   o_count,
  output logic [15:0]                              o_dropped,
  output logic [1:0]                               o_state,
  output logic [TS_WIDTH-1:0]                      o_cycle
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam int unsigned ENTRY_W = trace_entry_w(TAG_WIDTH, DATA_WIDTH, TS_WIDTH);

  trace_state_e        state_q, state_d;
  logic [TS_WIDTH-1:0] cycle_q;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [15:0]         dropped_q, dropped_d;
  logic                pend_valid_q, pend_valid_d;
  logic [ENTRY_W-1:0]  pend_entry_q, pend_entry_d;
  logic                rd_valid_q, rd_valid_d;

  logic                reg_ev, mem_ev, full, clear, wr_req;
  logic [ENTRY_W-1:0]  reg_entry, mem_entry;
  logic                ram_we, ram_re;
  logic [ENTRY_W-1:0]  ram_wdata;
  logic [1:0]          drop_inc;
  logic [16:0]         drop_sum;
  logic                unused_addr_bits;

  assign reg_ev    = i_wb_reg_write && (i_wb_write_register != 5'd0);
  assign mem_ev    = i_mem_write;
  assign reg_entry = {TRACE_KIND_REG, TAG_WIDTH'(i_wb_write_register), i_wb_write_data, cycle_q};
  assign mem_entry = {TRACE_KIND_MEM, i_mem_addr[TAG_WIDTH+1:2], i_mem_write_data, cycle_q};
  assign full      = (count_q == CW'(DEPTH));

  // Address bits outside the tag window are intentionally not traced.
  assign unused_addr_bits = ^{i_mem_addr[DATA_WIDTH-1:TAG_WIDTH+2], i_mem_addr[1:0]};

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pend_valid_d = pend_valid_q;
    pend_entry_d = pend_entry_q;
    rd_valid_d   = 1'b0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_wdata    = pend_entry_q;
    wr_req       = 1'b0;
    drop_inc     = 2'd0;
    clear        = 1'b0;

    unique case (state_q)
      TRACE_IDLE: begin
        if (i_stop) begin
          state_d = TRACE_STOPPED;
          clear   = 1'b1;
        end else if (i_arm) begin
          state_d = TRACE_ARMED;
          clear   = 1'b1;
        end
      end

      TRACE_ARMED: begin
        if (i_stop) begin
          state_d = TRACE_STOPPED;
        end else if (cycle_q == i_trig_cycle) begin
          state_d = TRACE_CAPTURE;
        end
      end

      TRACE_CAPTURE: begin
        // Candidate order is pending, register, memory: the first goes to
        // the buffer, the second to the pending slot, a third is dropped.
        if (pend_valid_q) begin
          wr_req    = 1'b1;
          ram_wdata = pend_entry_q;
          if (reg_ev) begin
            pend_entry_d = reg_entry;
            if (mem_ev) begin
              drop_inc = drop_inc + 2'd1;
            end
          end else if (mem_ev) begin
            pend_entry_d = mem_entry;
          end else begin
            pend_valid_d = 1'b0;
          end
        end else if (reg_ev) begin
          wr_req    = 1'b1;
          ram_wdata = reg_entry;
          if (mem_ev) begin
            pend_valid_d = 1'b1;
            pend_entry_d = mem_entry;
          end
        end else if (mem_ev) begin
          wr_req    = 1'b1;
          ram_wdata = mem_entry;
        end

        if (wr_req) begin
          if (!full) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + CW'(1);
          end else if (WRAP != 0) begin
            // Overwrite oldest: both pointers advance, count stays at DEPTH.
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            rd_ptr_d = rd_ptr_q + AW'(1);
          end else begin
            drop_inc = drop_inc + 2'd1;
          end
        end

        if (i_stop) begin
          state_d = TRACE_STOPPED;
        end else if ((WRAP == 0) && (count_d == CW'(DEPTH))) begin
          state_d = TRACE_STOPPED;
        end

        // A pending entry cannot survive leaving capture.
        if ((state_d != TRACE_CAPTURE) && pend_valid_d) begin
          pend_valid_d = 1'b0;
          drop_inc     = drop_inc + 2'd1;
        end
      end

      TRACE_STOPPED: begin
        if (i_arm && !i_stop) begin
          state_d = TRACE_ARMED;
          clear   = 1'b1;
        end else if (i_rd_en && (count_q != '0)) begin
          ram_re     = 1'b1;
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + AW'(1);
          count_d    = count_q - CW'(1);
        end
      end
    endcase

    drop_sum  = {1'b0, dropped_q} + 17'(drop_inc);
    dropped_d = drop_sum[16] ? '1 : drop_sum[15:0];

    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      dropped_d    = '0;
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= TRACE_IDLE;
      cycle_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dropped_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_entry_q <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_q + TS_WIDTH'(1);
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dropped_q    <= dropped_d;
      pend_valid_q <= pend_valid_d;
      pend_entry_q <= pend_entry_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  mips_commit_trace_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (o_rd_entry)
  );

  assign o_rd_valid = rd_valid_q;
  assign o_count    = count_q;
  assign o_dropped  = dropped_q;
  assign o_state    = state_q;
  assign o_cycle    = cycle_q;

endmodule
